fp_round_pack: RTL and testbench
================================

# fp_round_pack

Back-end normalizer, rounder and packer for the FP datapath. It consumes the unpacked result stream that the multiplier and divider emit: sign, biased exponent, 27-bit mantissa with guard/round/sticky, flags and mode. It produces a packed IEEE-754 binary32 or binary16 word plus final exception flags. It is a 2-stage valid/ready pipeline that sits between the arithmetic units and the register-file writeback.

## Interface
- No parameters; widths are fixed (binary32 internal format, bias 127).
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sign  in  1  result sign.
- in_exp  in  8  biased exponent (bias 127); 0 = subnormal/zero, 255 = Inf/NaN.
- in_mant  in  27  [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- in_flags  in  5  upstream flags, OR-ed into output; positions per `F_*` macros (NV, DZ, OF, UF, NX).
- in_mode_fp  in  1  1 = binary32 output, 0 = binary16 output.
- round_mode  in  1  0 = round-to-nearest-even, 1 = round-toward-zero; sampled with the beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- result  out  32  packed result; binary16 in [15:0], [31:16] = 0.
- flags  out  5  final exception flags.
- mode_fp_out  out  1  in_mode_fp carried with the beat.

## Operation
- Specials are decided in stage 1 and bypass rounding.
  - in_exp = 255 with in_mant[25:3] ≠ 0 → canonical NaN (0x7FC00000 / 0x7E00).
  - in_exp = 255 with zero fraction → ±Inf.
  - in_mant = 0 → ±0, exponent field 0.
- Normalization in stage 1:
  - Treat in_exp = 0 as effective exponent 1.
  - While mant[26] = 0 and exp > 1: shift left by 1, decrement exp. Use a leading-zero count, single cycle.
  - If exp = 1 and mant[26] = 0 after shifting, the result is subnormal: exponent field 0, tiny = 1.
- binary32 rounding:
  - lsb = m[3], g = m[2], r = m[1], s = m[0].
  - RNE: up = g & (r | s | lsb). RTZ: up = 0.
  - Packed magnitude = {expfield, m[25:3]} + up, as a 31-bit add. Carry naturally moves subnormal→normal and frac overflow→exp+1.
- binary16 path:
  - Rebias e16 = exp − 112.
  - frac = m[25:16], g = m[15], r = m[14], s = |m[13:0].
  - e16 ≤ 0 → flush to ±0, UF|NX.
- Overflow:
  - Triggers when the magnitude after rounding reaches the Inf encoding (0x7F800000 / 0x7C00) or the exponent exceeds the range.
  - RNE → ±Inf; RTZ → ±max finite (0x7F7FFFFF / 0x7BFF).
  - Sets OF|NX.
- Flags:
  - NX = g | r | s (non-special).
  - UF = tiny & NX.
  - Output flags = in_flags | generated.
  - Specials generate nothing beyond in_flags.

## Timing
- Latency is 2 cycles from the accept edge (in_valid & in_ready) to out_valid. Throughput is 1 beat/cycle.
- Pipeline control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready).
- Stage registers load only when their advance term is high. Data holds stable while out_valid & !out_ready.
- Simultaneous accept and emit in one cycle is legal; no bubble is inserted.
- Reset (rst_n = 0 at a clk edge):
  - s1_valid, s2_valid, out_valid ← 0.
  - result, flags, mode_fp_out ← 0.
  - In-flight beats are discarded.
  - in_ready = 1 on the first cycle after reset deasserts.
- Reset mid-stall drops all held data. No partial output appears.

## Test plan
- Basic conversions, all with out_ready = 1:
  - exp = 127, mant = 0x4000000, RNE, mode 1 → result 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
  - Same beat with mode 0 → 0x00003C00.
- Rounding: exp = 127, mant = 0x400000C (lsb = 1, g = 1).
  - RNE → 0x3F800002, NX.
  - RTZ → 0x3F800001, NX.
- Overflow: exp = 254, mant = 0x7FFFFFC, sign 0.
  - RNE → 0x7F800000, OF|NX.
  - RTZ → 0x7F7FFFFF, OF|NX.
- Specials and subnormals:
  - exp = 255, mant = 0x4000008, in_flags = NV → 0x7FC00000, flags = NV.
  - exp = 0, mant = 0x0000008 → 0x00000001, flags 0.
- Backpressure: 4 back-to-back beats with out_ready = 0 for 6 cycles → in_ready falls after 2 accepts. Results are emitted in order with none lost or duplicated, and result stays stable while stalled.
- Reset mid-operation: both stages full, rst_n = 0 for one cycle → out_valid = 0 and flags = 0 next cycle. The next accepted beat emerges 2 cycles after its accept.

Source files
------------

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalizes, rounds and packs the unpacked FP result stream
// from the multiplier/divider into binary32 or binary16, with final flags.
// Two-stage valid/ready pipeline:
//   stage 1 decides specials and normalizes (leading-zero count + shift),
//   stage 2 rounds, detects overflow/underflow and packs into the output regs.
`timescale 1ns/1ps

module fp_round_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic [4:0]  in_flags,
    input  logic        in_mode_fp,
    input  logic        round_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        mode_fp_out
);

    // Exception flag bit positions (NV, DZ, OF, UF, NX from msb to lsb)
    localparam int F_NV = 4;
    localparam int F_DZ = 3;
    localparam int F_OF = 2;
    localparam int F_UF = 1;
    localparam int F_NX = 0;

    localparam logic [30:0] INF32_MAG  = 31'h7F800000;
    localparam logic [14:0] INF16_MAG  = 15'h7C00;

    // Leading-zero count of a 27-bit mantissa (27 when all zero)
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Round-up decision: nearest-even unless truncating toward zero
    function automatic logic round_up(input logic lsb, input logic g,
                                      input logic r, input logic s,
                                      input logic rtz);
        return rtz ? 1'b0 : (g & (r | s | lsb));
    endfunction

    // Overflowed binary32 magnitude: Inf when rounding to nearest, max finite when truncating
    function automatic logic [30:0] sat32(input logic rtz);
        return rtz ? 31'h7F7FFFFF : INF32_MAG;
    endfunction

    // Overflowed binary16 magnitude: Inf when rounding to nearest, max finite when truncating
    function automatic logic [14:0] sat16(input logic rtz);
        return rtz ? 15'h7BFF : INF16_MAG;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic vld_p1_q;
    logic vld_p2_q;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !vld_p2_q | out_ready;
    assign s1_adv   = !vld_p1_q | s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: special decode and normalization
    // ------------------------------------------------------------------
    logic        is_nan_p0;
    logic        is_inf_p0;
    logic        is_zero_p0;
    logic [7:0]  exp_eff_p0;
    logic [4:0]  lzc_p0;
    logic [7:0]  max_sh_p0;
    logic [7:0]  sh_p0;
    logic [26:0] mant_n_p0;
    logic [7:0]  exp_n_p0;

    assign is_nan_p0  = (in_exp == 8'hFF) && (in_mant[25:3] != 23'd0);
    assign is_inf_p0  = (in_exp == 8'hFF) && (in_mant[25:3] == 23'd0);
    assign is_zero_p0 = (in_exp != 8'hFF) && (in_mant == 27'd0);

    // Exponent field 0 behaves as exponent 1 (subnormal scale)
    assign exp_eff_p0 = (in_exp == 8'd0) ? 8'd1 : in_exp;
    assign lzc_p0     = lzc27(in_mant);
    // Shift stops once the exponent reaches 1; anything left unnormalized is subnormal
    assign max_sh_p0  = exp_eff_p0 - 8'd1;
    assign sh_p0      = ({3'b000, lzc_p0} > max_sh_p0) ? max_sh_p0 : {3'b000, lzc_p0};
    assign mant_n_p0  = in_mant << sh_p0;
    assign exp_n_p0   = exp_eff_p0 - sh_p0;

    logic        sign_p1_d,    sign_p1_q;
    logic [7:0]  exp_p1_d,     exp_p1_q;
    logic [25:0] mant_p1_d,    mant_p1_q;
    logic        tiny_p1_d,    tiny_p1_q;
    logic        special_p1_d, special_p1_q;
    logic [31:0] spec_p1_d,    spec_p1_q;
    logic [4:0]  flags_p1_d,   flags_p1_q;
    logic        mode_p1_d,    mode_p1_q;
    logic        rm_p1_d,      rm_p1_q;

    // Stage-1 next state: special encodings and the normalized operand
    always_comb begin
        sign_p1_d    = in_sign;
        exp_p1_d     = exp_n_p0;
        mant_p1_d    = mant_n_p0[25:0];
        tiny_p1_d    = ~mant_n_p0[26];
        special_p1_d = is_nan_p0 | is_inf_p0 | is_zero_p0;
        flags_p1_d   = in_flags;
        mode_p1_d    = in_mode_fp;
        rm_p1_d      = round_mode;
        spec_p1_d    = 32'd0;
        if (is_nan_p0) begin
            spec_p1_d = in_mode_fp ? 32'h7FC00000 : 32'h00007E00;
        end else if (is_inf_p0) begin
            spec_p1_d = in_mode_fp ? {in_sign, 8'hFF, 23'd0}
                                   : {16'd0, in_sign, 5'h1F, 10'd0};
        end else if (is_zero_p0) begin
            spec_p1_d = in_mode_fp ? {in_sign, 31'd0} : {16'd0, in_sign, 15'd0};
        end
    end

    // Stage-1 valid: advances whenever the stage can hand off or is empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else if (s1_adv) begin
            vld_p1_q <= in_valid;
        end
    end

    // Stage-1 data: loads only on an accepted beat
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            sign_p1_q    <= sign_p1_d;
            exp_p1_q     <= exp_p1_d;
            mant_p1_q    <= mant_p1_d;
            tiny_p1_q    <= tiny_p1_d;
            special_p1_q <= special_p1_d;
            spec_p1_q    <= spec_p1_d;
            flags_p1_q   <= flags_p1_d;
            mode_p1_q    <= mode_p1_d;
            rm_p1_q      <= rm_p1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rounding, overflow/underflow and packing
    // ------------------------------------------------------------------
    logic [7:0]  ef32_p1;
    logic [30:0] base32_p1;
    logic [30:0] mag32_p1;
    logic [30:0] mag_ne32_p1;
    logic        ovf32_p1;
    logic        nx32_p1;

    assign ef32_p1     = tiny_p1_q ? 8'd0 : exp_p1_q;
    assign base32_p1   = {ef32_p1, mant_p1_q[25:3]};
    assign mag32_p1    = base32_p1 + {30'd0, round_up(mant_p1_q[3], mant_p1_q[2],
                                                      mant_p1_q[1], mant_p1_q[0], rm_p1_q)};
    // Overflow is judged on the nearest-rounded value so truncation still reports it
    assign mag_ne32_p1 = base32_p1 + {30'd0, round_up(mant_p1_q[3], mant_p1_q[2],
                                                      mant_p1_q[1], mant_p1_q[0], 1'b0)};
    assign ovf32_p1    = (mag_ne32_p1 >= INF32_MAG);
    assign nx32_p1     = mant_p1_q[2] | mant_p1_q[1] | mant_p1_q[0];

    logic signed [9:0] e16_p1;
    logic        g16_p1;
    logic        r16_p1;
    logic        s16_p1;
    logic [14:0] base16_p1;
    logic [14:0] mag16_p1;
    logic [14:0] mag_ne16_p1;
    logic        flush16_p1;
    logic        ovf16_p1;
    logic        nx16_p1;

    assign e16_p1      = $signed({2'b00, exp_p1_q}) - 10'sd112;
    assign g16_p1      = mant_p1_q[15];
    assign r16_p1      = mant_p1_q[14];
    assign s16_p1      = |mant_p1_q[13:0];
    assign base16_p1   = {e16_p1[4:0], mant_p1_q[25:16]};
    assign mag16_p1    = base16_p1 + {14'd0, round_up(mant_p1_q[16], g16_p1,
                                                      r16_p1, s16_p1, rm_p1_q)};
    assign mag_ne16_p1 = base16_p1 + {14'd0, round_up(mant_p1_q[16], g16_p1,
                                                      r16_p1, s16_p1, 1'b0)};
    // binary16 has no subnormal outputs here: anything below its normal range flushes
    assign flush16_p1  = (e16_p1 <= 10'sd0);
    assign ovf16_p1    = (e16_p1 >= 10'sd31) || (mag_ne16_p1 >= INF16_MAG);
    assign nx16_p1     = g16_p1 | r16_p1 | s16_p1;

    logic [31:0] result_d, result_q;
    logic [4:0]  flags_d,  flags_q;
    logic        mode_d,   mode_q;
    logic [4:0]  gen_p1;

    // Stage-2 next state: pick special, overflow, flush or rounded encoding
    always_comb begin
        gen_p1   = 5'd0;
        result_d = 32'd0;
        if (special_p1_q) begin
            result_d = spec_p1_q;
        end else if (mode_p1_q) begin
            if (ovf32_p1) begin
                result_d     = {sign_p1_q, sat32(rm_p1_q)};
                gen_p1[F_OF] = 1'b1;
                gen_p1[F_NX] = 1'b1;
            end else begin
                result_d     = {sign_p1_q, mag32_p1};
                gen_p1[F_NX] = nx32_p1;
                gen_p1[F_UF] = tiny_p1_q & nx32_p1;
            end
        end else begin
            if (flush16_p1) begin
                result_d     = {16'd0, sign_p1_q, 15'd0};
                gen_p1[F_UF] = 1'b1;
                gen_p1[F_NX] = 1'b1;
            end else if (ovf16_p1) begin
                result_d     = {16'd0, sign_p1_q, sat16(rm_p1_q)};
                gen_p1[F_OF] = 1'b1;
                gen_p1[F_NX] = 1'b1;
            end else begin
                result_d     = {16'd0, sign_p1_q, mag16_p1};
                gen_p1[F_NX] = nx16_p1;
            end
        end
        flags_d = flags_p1_q | gen_p1;
        mode_d  = mode_p1_q;
    end

    // Output stage: holds while stalled, cleared entirely by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
            mode_q   <= 1'b0;
        end else begin
            if (s2_adv) begin
                vld_p2_q <= vld_p1_q;
            end
            if (s2_adv && vld_p1_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
                mode_q   <= mode_d;
            end
        end
    end

    assign out_valid   = vld_p2_q;
    assign result      = result_q;
    assign flags       = flags_q;
    assign mode_fp_out = mode_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Testbench for fp_round_pack: scoreboard of expected packed results,
// pushed on accept and compared on output handshake.
`timescale 1ns/1ps

module tb_fp_round_pack;

    localparam logic [4:0] NV = 5'h10;
    localparam logic [4:0] DZ = 5'h08;
    localparam logic [4:0] OF = 5'h04;
    localparam logic [4:0] UF = 5'h02;
    localparam logic [4:0] NX = 5'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic [4:0]  in_flags;
    logic        in_mode_fp;
    logic        round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        mode_fp_out;

    always #5 clk = ~clk;

    fp_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_flags   (in_flags),
        .in_mode_fp (in_mode_fp),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .mode_fp_out(mode_fp_out)
    );

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [26:0] m;
        logic [4:0]  f;
        logic        md;
        logic        rm;
        logic [31:0] xr;
        logic [4:0]  xf;
    } beat_t;

    typedef struct {
        logic [31:0] xr;
        logic [4:0]  xf;
        logic        md;
        bit          lat;
        int          acc;
        int          id;
    } sb_t;

    sb_t   sb[$];
    beat_t tbl[$];

    logic [31:0] drv_xr;
    logic [4:0]  drv_xf;
    bit          drv_lat;
    int          drv_id;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int beat_id  = 0;
    int bp_base;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp_v);
        end
    endtask

    function automatic beat_t mk(input logic s, input logic [7:0] e, input logic [26:0] m,
                                 input logic [4:0] f, input logic md, input logic rm,
                                 input logic [31:0] xr, input logic [4:0] xf);
        beat_t b;
        b.s = s; b.e = e; b.m = m; b.f = f; b.md = md; b.rm = rm; b.xr = xr; b.xf = xf;
        return b;
    endfunction

    // Monitor: sample half a cycle away from the active edge
    always @(negedge clk) begin : mon
        sb_t e;
        cyc++;
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb[0];
                    check_eq($sformatf("res#%0d", e.id), result, e.xr);
                    if (out_ready) begin
                        check_eq($sformatf("flags#%0d", e.id), {27'd0, flags}, {27'd0, e.xf});
                        check_eq($sformatf("mode#%0d", e.id), {31'd0, mode_fp_out}, {31'd0, e.md});
                        if (e.lat)
                            check_eq($sformatf("latency#%0d", e.id), 32'(cyc - e.acc), 32'd2);
                        void'(sb.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.xr  = drv_xr;
                e.xf  = drv_xf;
                e.md  = in_mode_fp;
                e.lat = drv_lat;
                e.acc = cyc;
                e.id  = drv_id;
                sb.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic send(input beat_t b, input bit lat);
        int w;
        in_valid   = 1'b1;
        in_sign    = b.s;
        in_exp     = b.e;
        in_mant    = b.m;
        in_flags   = b.f;
        in_mode_fp = b.md;
        round_mode = b.rm;
        drv_xr     = b.xr;
        drv_xf     = b.xf;
        drv_lat    = lat;
        drv_id     = beat_id;
        beat_id++;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check_eq("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 27'd0;
        in_flags = 5'd0; in_mode_fp = 1'b0; round_mode = 1'b0; out_ready = 1'b1;
        drv_xr = 32'd0; drv_xf = 5'd0; drv_lat = 1'b0; drv_id = 0;

        //             s  exp    mant           in_flg md rm  result        flags
        tbl.push_back(mk(0, 8'd127, 27'h4000000, 5'd0, 1, 0, 32'h3F800000, 5'd0));
        tbl.push_back(mk(0, 8'd127, 27'h4000000, 5'd0, 0, 0, 32'h00003C00, 5'd0));
        tbl.push_back(mk(0, 8'd127, 27'h400000C, 5'd0, 1, 0, 32'h3F800002, NX));
        tbl.push_back(mk(0, 8'd127, 27'h400000C, 5'd0, 1, 1, 32'h3F800001, NX));
        tbl.push_back(mk(0, 8'd254, 27'h7FFFFFC, 5'd0, 1, 0, 32'h7F800000, OF | NX));
        tbl.push_back(mk(0, 8'd254, 27'h7FFFFFC, 5'd0, 1, 1, 32'h7F7FFFFF, OF | NX));
        tbl.push_back(mk(0, 8'd255, 27'h4000008, NV,   1, 0, 32'h7FC00000, NV));
        tbl.push_back(mk(0, 8'd0,   27'h0000008, 5'd0, 1, 0, 32'h00000001, 5'd0));
        tbl.push_back(mk(0, 8'd255, 27'h4000008, 5'd0, 0, 0, 32'h00007E00, 5'd0));
        tbl.push_back(mk(1, 8'd255, 27'h4000000, 5'd0, 1, 0, 32'hFF800000, 5'd0));
        tbl.push_back(mk(1, 8'd255, 27'h0000000, 5'd0, 0, 0, 32'h0000FC00, 5'd0));
        tbl.push_back(mk(1, 8'd5,   27'h0000000, 5'd0, 1, 0, 32'h80000000, 5'd0));
        tbl.push_back(mk(1, 8'd5,   27'h0000000, 5'd0, 0, 0, 32'h00008000, 5'd0));
        tbl.push_back(mk(0, 8'd0,   27'h3FFFFFC, 5'd0, 1, 0, 32'h00800000, UF | NX));
        tbl.push_back(mk(0, 8'd2,   27'h1000000, 5'd0, 1, 0, 32'h00400000, 5'd0));
        tbl.push_back(mk(0, 8'd130, 27'h1000000, 5'd0, 1, 0, 32'h40000000, 5'd0));
        tbl.push_back(mk(0, 8'd127, 27'h4000004, 5'd0, 1, 0, 32'h3F800000, NX));
        tbl.push_back(mk(0, 8'd127, 27'h4018000, 5'd0, 0, 0, 32'h00003C02, NX));
        tbl.push_back(mk(0, 8'd127, 27'h4018000, 5'd0, 0, 1, 32'h00003C01, NX));
        tbl.push_back(mk(1, 8'd200, 27'h4000000, 5'd0, 0, 0, 32'h0000FC00, OF | NX));
        tbl.push_back(mk(1, 8'd200, 27'h4000000, 5'd0, 0, 1, 32'h0000FBFF, OF | NX));
        tbl.push_back(mk(0, 8'd100, 27'h4000000, 5'd0, 0, 0, 32'h00000000, UF | NX));
        tbl.push_back(mk(0, 8'd127, 27'h4000000, DZ,   1, 0, 32'h3F800000, DZ));
        tbl.push_back(mk(1, 8'd129, 27'h6000000, 5'd0, 0, 0, 32'h0000C600, 5'd0));

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags", {27'd0, flags}, 32'd0);
        check_eq("rst_mode", {31'd0, mode_fp_out}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed conversions, back to back with no backpressure
        foreach (tbl[i]) send(tbl[i], 1'b1);
        idle();
        wait_drain();

        // Backpressure: four beats offered while the output is stalled
        out_ready = 1'b0;
        bp_base   = acc_cnt;
        fork
            begin
                send(mk(0, 8'd127, 27'h4000000, 5'd0, 1, 0, 32'h3F800000, 5'd0), 1'b0);
                send(mk(0, 8'd128, 27'h4000000, 5'd0, 1, 0, 32'h40000000, 5'd0), 1'b0);
                send(mk(0, 8'd126, 27'h4000000, 5'd0, 1, 0, 32'h3F000000, 5'd0), 1'b0);
                send(mk(0, 8'd128, 27'h6000000, 5'd0, 1, 0, 32'h40400000, 5'd0), 1'b0);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                #1;
                check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check_eq("bp_accepts", 32'(acc_cnt - bp_base), 32'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check_eq("bp_total_accepts", 32'(acc_cnt - bp_base), 32'd4);

        // Reset while both stages hold a beat
        out_ready = 1'b0;
        send(mk(0, 8'd255, 27'h4000008, NV, 1, 0, 32'h7FC00000, NV), 1'b0);
        send(mk(0, 8'd128, 27'h4000000, 5'd0, 1, 0, 32'h40000000, 5'd0), 1'b0);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sb.delete();
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_flags", {27'd0, flags}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        send(mk(0, 8'd129, 27'h6000000, 5'd0, 1, 0, 32'h40C00000, 5'd0), 1'b1);
        idle();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
